hamming_enc: RTL and testbench
==============================

HAMMING_ENC -- requirements
Module: hamming_enc

Interface
REQ-001 SHALL have parameter DATA_W, default 4, data bits per word; legal values 4, 11, 26.
REQ-002 SHALL derive localparam PAR_W (3, 4, 5 for DATA_W 4, 11, 26) and CW_W = DATA_W+PAR_W, plus 1 when HAMMING_SECDED_EN is defined.
REQ-003 SHALL have clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have din  input  DATA_W  data word to encode.
REQ-006 SHALL have din_val  input  1  din valid.
REQ-007 SHALL have din_rdy  output  1  encoder can accept; transfer when din_val && din_rdy.
REQ-008 SHALL have eout  output  CW_W  codeword, same bit ordering the team decoder consumes on ein.
REQ-009 SHALL have eout_val  output  1  eout valid.
REQ-010 SHALL have eout_rdy  input  1  sink accepts; transfer when eout_val && eout_rdy.
REQ-011 SHALL have word_cnt  output  16  count of codewords delivered on the output side.

Function
REQ-012 Codeword position i (1-based) SHALL drive eout[i-1]; parity bits at power-of-two positions; din[0] upward fills the remaining positions in ascending order.
REQ-013 Parity at position 2^k SHALL be the XOR of all data positions whose index has bit k set (even parity).
REQ-014 Accepted words SHALL enter a 2-entry output FIFO; eout_val SHALL rise the cycle after acceptance (latency 1); no combinational path from din to eout.
REQ-015 din_rdy SHALL be registered: high when the FIFO holds 0 entries, or 1 entry with no pending write; it SHALL NOT depend combinationally on eout_rdy.
REQ-016 Simultaneous accept and deliver with 1 entry SHALL keep occupancy at 1 and pass data in order; with 2 entries, deliver-only SHALL drop to 1.
REQ-017 eout and eout_val SHALL hold stable while eout_val && !eout_rdy.
REQ-018 word_cnt SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-019 Input data SHALL be encoded on entry and stored as codewords; order SHALL be strictly FIFO.

Reset
REQ-020 While rst is low: eout_val=0, din_rdy=0, eout=0, word_cnt=0, FIFO empty.
REQ-021 din_rdy SHALL rise on the first clk edge after rst deasserts.
REQ-022 Reset mid-transfer SHALL discard all buffered words with no partial output.

Configuration
REQ-023 Macro HAMMING_SECDED_EN defined: eout[CW_W-1] SHALL be the XOR of all other codeword bits, giving an overall even-parity SECDED code.
REQ-024 Macro undefined: CW_W = DATA_W+PAR_W; the extra bit and its logic SHALL be absent.

Structure
REQ-025 Package hamming_pkg SHALL hold the PAR_W function, the position-is-parity helper and the CW_W derivation, shared with dec.
REQ-026 Parity generation SHALL be the combinational sub-module hamming_par_gen (din -> codeword).
REQ-027 The FIFO, handshake and counter SHALL live in hamming_enc.

Verification
REQ-028 DATA_W=4, din=4'b1011, eout_rdy=1 -> next cycle eout=7'b1010101, eout_val=1, word_cnt=1 after transfer.
REQ-029 din=4'b0001 -> 7'b0000111; din=4'b0000 -> 7'b0000000; din=4'b1111 -> 7'b1111111.
REQ-030 HAMMING_SECDED_EN, din=4'b1111 -> 8'b11111111; din=4'b1011 -> 8'b01010101.
REQ-031 eout_rdy=0, 3 words offered back-to-back -> 2 accepted, din_rdy low, eout held; eout_rdy=1 -> both delivered in order.
REQ-032 Loopback to dec: all 16 data values, each with every single-bit flip injected between the blocks -> dec dout equals original din.
REQ-033 rst pulsed low with 2 words buffered -> eout_val=0 and word_cnt=0 immediately; no stale word after release.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming helpers for encoder and decoder: parity-width and codeword-width derivation.
// Build option: define HAMMING_SECDED_EN to append an overall even-parity bit (SECDED).
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
    localparam int unsigned SecdedW = 1;
`else
    localparam int unsigned SecdedW = 0;
`endif

    typedef logic [1:0] occ_t;

    // Smallest r with 2^r >= data + r + 1.
    function automatic int unsigned par_w_f(input int unsigned dw);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < dw + r + 1) r = r + 1;
        return r;
    endfunction

    function automatic bit is_par_pos(input int unsigned pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    function automatic int unsigned ham_w_f(input int unsigned dw);
        return dw + par_w_f(dw);
    endfunction

    function automatic int unsigned cw_w_f(input int unsigned dw);
        return ham_w_f(dw) + SecdedW;
    endfunction

    // Data positions (1-based) covered by the parity bit at position 2^k.
    function automatic logic [31:0] par_mask(input int unsigned k);
        logic [31:0] m;
        m = '0;
        for (int unsigned p = 1; p < 32; p++) begin
            if (((p >> k) & 32'd1) == 32'd1 && !is_par_pos(p)) m[p-1] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_par_gen.sv
// Combinational Hamming codeword generator: data word in, codeword out (position i on bit i-1).
// Build option: HAMMING_SECDED_EN adds the overall parity bit in the MSB.
module hamming_par_gen
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CW_W   = cw_w_f(DATA_W)
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   cw_o
);

    localparam int unsigned HamW = ham_w_f(DATA_W);
    localparam int unsigned ParW = par_w_f(DATA_W);

    logic [HamW-1:0] data_pos;
    logic [HamW-1:0] ham;

    // Non-parity position p holds data bit p-1-clog2(p): the powers of two below p are skipped.
    for (genvar p = 1; p <= HamW; p++) begin : g_pos
        if (is_par_pos(p)) begin : g_par
            assign data_pos[p-1] = 1'b0;
        end else begin : g_dat
            assign data_pos[p-1] = data_i[p-1-$clog2(p)];
            assign ham[p-1]      = data_pos[p-1];
        end
    end

    for (genvar k = 0; k < ParW; k++) begin : g_parity
        localparam logic [31:0] Mask = par_mask(k);
        assign ham[(1 << k) - 1] = ^(data_pos & Mask[HamW-1:0]);
    end

`ifdef HAMMING_SECDED_EN
    assign cw_o = {^ham, ham};
`else
    assign cw_o = ham;
`endif

endmodule

// File: rtl/hamming_enc.sv
// Hamming encoder with valid/ready handshake, 2-entry codeword FIFO and delivered-word counter.
// Build option: HAMMING_SECDED_EN widens the codeword by one overall-parity bit.
module hamming_enc
    import hamming_pkg::*;
#(
    parameter  int unsigned DATA_W = 4,
    localparam int unsigned PAR_W  = par_w_f(DATA_W),
    localparam int unsigned CW_W   = DATA_W + PAR_W + SecdedW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_val,
    output logic              din_rdy,
    output logic [CW_W-1:0]   eout,
    output logic              eout_val,
    input  logic              eout_rdy,
    output logic [15:0]       word_cnt
);

    logic [CW_W-1:0] cw;
    logic [CW_W-1:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    occ_t            cnt_q, cnt_d;
    logic            rdy_q;
    logic [15:0]     word_cnt_q;
    logic            push, pop;

    hamming_par_gen #(
        .DATA_W(DATA_W),
        .CW_W  (CW_W)
    ) u_par_gen (
        .data_i(din),
        .cw_o  (cw)
    );

    assign push = din_val && rdy_q;
    assign pop  = eout_val && eout_rdy;

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Ready is registered from next occupancy so it never sees eout_rdy combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rdy_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d < 2'd2);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cw;
    end

    assign din_rdy  = rdy_q;
    assign eout_val = (cnt_q != 2'd0);
    assign eout     = eout_val ? mem_q[rd_ptr_q] : '0;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_hamming_enc.sv
// Bench for hamming_enc (DATA_W=4): queue-based reference model checked every cycle,
// behavioural single-error-correcting decode loopback, and directed literal vectors.
module tb_hamming_enc;

    localparam int unsigned DW = 4;
`ifdef HAMMING_SECDED_EN
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] E1011 = 8'b01010101;
    localparam logic [CW-1:0] E0001 = 8'b10000111;
    localparam logic [CW-1:0] E0000 = 8'b00000000;
    localparam logic [CW-1:0] E1111 = 8'b11111111;
`else
    localparam int unsigned CW = 7;
    localparam logic [CW-1:0] E1011 = 7'b1010101;
    localparam logic [CW-1:0] E0001 = 7'b0000111;
    localparam logic [CW-1:0] E0000 = 7'b0000000;
    localparam logic [CW-1:0] E1111 = 7'b1111111;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_val = 1'b0;
    logic          eout_rdy = 1'b0;
    logic          din_rdy;
    logic          eout_val;
    logic [CW-1:0] eout;
    logic [15:0]   word_cnt;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] mq[$];
    logic [DW-1:0] dq[$];
    logic          m_rdy = 1'b0;
    logic [15:0]   m_cnt = '0;
    logic          m_acc, m_dlv;
    logic          lb_ok;
    logic [CW-1:0] lb_c;
    logic          stim_r;

    always #5 clk = ~clk;

    hamming_enc #(.DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_val (din_val),
        .din_rdy (din_rdy),
        .eout    (eout),
        .eout_val(eout_val),
        .eout_rdy(eout_rdy),
        .word_cnt(word_cnt)
    );

    function automatic logic [CW-1:0] enc_model(input logic [DW-1:0] d);
        logic [CW-1:0] c = '0;
        int j = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            logic b;
            b = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (pos != p && (pos & p) != 0) b = b ^ c[pos-1];
            end
            c[p-1] = b;
        end
`ifdef HAMMING_SECDED_EN
        c[CW-1] = ^c[6:0];
`endif
        return c;
    endfunction

    function automatic logic [DW-1:0] dec_model(input logic [CW-1:0] c);
        logic [6:0]    h = c[6:0];
        logic [DW-1:0] d = '0;
        int syn = 0;
        int j = 0;
        for (int pos = 1; pos <= 7; pos++) if (h[pos-1]) syn = syn ^ pos;
        if (syn != 0) h[syn-1] = ~h[syn-1];
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = h[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_lit(input logic [DW-1:0] d, input logic [CW-1:0] exp, input string nm);
        din     = d;
        din_val = 1'b1;
        tick();
        din_val = 1'b0;
        chk({nm, "_eout"}, 32'(eout), 32'(exp));
        chk({nm, "_val"}, 32'(eout_val), 32'd1);
        tick();
    endtask

    // Reference model: updates on the same edges as the DUT using pre-edge inputs.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            dq.delete();
            m_rdy = 1'b0;
            m_cnt = '0;
        end else begin
            m_acc = din_val && m_rdy;
            m_dlv = eout_rdy && (mq.size() > 0);
            if (m_dlv) begin
                void'(mq.pop_front());
                void'(dq.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (m_acc) begin
                mq.push_back(enc_model(din));
                dq.push_back(din);
            end
            m_rdy = (mq.size() < 2);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("din_rdy", 32'(din_rdy), 32'(m_rdy));
            chk("eout_val", 32'(eout_val), 32'(mq.size() > 0));
            chk("eout", 32'(eout), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
            if (eout_val && eout_rdy && dq.size() > 0) begin
                lb_ok = 1'b1;
                for (int f = 0; f <= int'(CW); f++) begin
                    lb_c = eout;
                    if (f < int'(CW)) lb_c[f] = ~lb_c[f];
                    if (dec_model(lb_c) !== dq[0]) lb_ok = 1'b0;
                end
                chk("loopback", 32'(lb_ok), 32'd1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        chk("rst_rdy", 32'(din_rdy), 32'd0);
        chk("rst_val", 32'(eout_val), 32'd0);
        chk("rst_eout", 32'(eout), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        chk("rdy_after_rst", 32'(din_rdy), 32'd1);

        eout_rdy = 1'b1;
        send_lit(4'b1011, E1011, "v1011");
        chk("cnt_first", 32'(word_cnt), 32'd1);
        send_lit(4'b0001, E0001, "v0001");
        send_lit(4'b0000, E0000, "v0000");
        send_lit(4'b1111, E1111, "v1111");
        chk("cnt_four", 32'(word_cnt), 32'd4);

        // Backpressure: three offered, two taken, head held.
        eout_rdy = 1'b0;
        din_val  = 1'b1;
        din = 4'b0001; tick();
        din = 4'b1011; tick();
        din = 4'b1111; tick();
        din_val = 1'b0;
        chk("bp_rdy_low", 32'(din_rdy), 32'd0);
        chk("bp_head", 32'(eout), 32'(E0001));
        repeat (3) tick();
        chk("bp_hold", 32'(eout), 32'(E0001));
        chk("bp_hold_val", 32'(eout_val), 32'd1);
        eout_rdy = 1'b1;
        tick();
        chk("bp_second", 32'(eout), 32'(E1011));
        tick();
        chk("bp_drained", 32'(eout_val), 32'd0);
        chk("bp_cnt", 32'(word_cnt), 32'd6);

        // All 16 values under varying sink readiness.
        for (int v = 0; v < 16; v++) begin
            din     = v[DW-1:0];
            din_val = 1'b1;
            stim_r  = 1'b0;
            for (int w = 0; w < 20 && !stim_r; w++) begin
                eout_rdy = ((v + w) % 3 != 0);
                @(negedge clk);
                stim_r = din_rdy;
                tick();
            end
            chk("stream_accept", 32'(stim_r), 32'd1);
        end
        din_val  = 1'b0;
        eout_rdy = 1'b1;
        repeat (4) tick();

        // Counter wrap.
        din_val = 1'b1;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
            din = i[DW-1:0];
            tick();
        end
        din_val = 1'b0;
        chk("cnt_ffff", 32'(word_cnt), 32'hFFFF);
        tick();
        chk("cnt_wrap", 32'(word_cnt), 32'd0);
        repeat (2) tick();
        send_lit(4'b0101, enc_model(4'b0101), "v0101");

        // Reset with two words buffered.
        eout_rdy = 1'b0;
        din_val  = 1'b1;
        din = 4'b0110; tick();
        din = 4'b1001; tick();
        din_val = 1'b0;
        chk("pre_rst_val", 32'(eout_val), 32'd1);
        chk("pre_rst_rdy", 32'(din_rdy), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_val", 32'(eout_val), 32'd0);
        chk("mid_rst_cnt", 32'(word_cnt), 32'd0);
        chk("mid_rst_eout", 32'(eout), 32'd0);
        chk("mid_rst_rdy", 32'(din_rdy), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        eout_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale", 32'(eout_val), 32'd0);
        end
        chk("post_rst_cnt", 32'(word_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
